// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: same-cycle stall/flush enables for a 5-stage pipe,
// multicycle EX sequencing and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  IFID_RS,
  input  logic [3:0]  IFID_RT,
  input  logic        IFID_USES_RT,
  input  logic [3:0]  IDEX_RT,
  input  logic        IDEX_MemRead,
  input  logic        BRANCH_TAKEN,
  input  logic        MC_START,
  input  logic        MEM_BUSY,
  input  logic        CNT_CLR,
  output logic        PC_WRITE,
  output logic        IFID_WRITE,
  output logic        IDEX_WRITE,
  output logic        EXMEM_WRITE,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        EXMEM_FLUSH,
  output logic        BUSY,
  output logic        MC_DONE,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT
);

  typedef enum logic {S_RUN, S_MC_BUSY} state_e;

  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;
  logic        branch_flush;

  assign load_use = IDEX_MemRead &&
                    ((IDEX_RT == IFID_RS) || (IFID_USES_RT && (IDEX_RT == IFID_RT)));

  always_comb begin
    PC_WRITE     = 1'b1;
    IFID_WRITE   = 1'b1;
    IDEX_WRITE   = 1'b1;
    EXMEM_WRITE  = 1'b1;
    IFID_FLUSH   = 1'b0;
    IDEX_FLUSH   = 1'b0;
    EXMEM_FLUSH  = 1'b0;
    MC_DONE      = 1'b0;
    BUSY         = (state_q == S_MC_BUSY);
    branch_flush = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (rst) begin
      PC_WRITE    = 1'b0;
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      EXMEM_FLUSH = 1'b1;
      BUSY        = 1'b0;
      state_d     = S_RUN;
      cnt_d       = '0;
    end else if (MEM_BUSY) begin
      PC_WRITE    = 1'b0;
      IFID_WRITE  = 1'b0;
      IDEX_WRITE  = 1'b0;
      EXMEM_WRITE = 1'b0;
    end else if (state_q == S_RUN) begin
      if (BRANCH_TAKEN) begin
        IFID_FLUSH   = 1'b1;
        IDEX_FLUSH   = 1'b1;
        branch_flush = 1'b1;
      end else if (MC_START) begin
        PC_WRITE    = 1'b0;
        IFID_WRITE  = 1'b0;
        IDEX_WRITE  = 1'b0;
        EXMEM_FLUSH = 1'b1;
        state_d     = S_MC_BUSY;
        cnt_d       = MC_LOAD;
      end else if (load_use) begin
        PC_WRITE   = 1'b0;
        IFID_WRITE = 1'b0;
        IDEX_FLUSH = 1'b1;
      end
    end else begin
      // In MC_BUSY all other hazard requests are ignored, including on release.
      if (cnt_q > 4'd1) begin
        PC_WRITE    = 1'b0;
        IFID_WRITE  = 1'b0;
        IDEX_WRITE  = 1'b0;
        EXMEM_FLUSH = 1'b1;
        cnt_d       = cnt_q - 4'd1;
      end else begin
        MC_DONE = 1'b1;
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CNT_CLR) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (!rst) begin
      if (!PC_WRITE && !MEM_BUSY && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (branch_flush && (flush_cnt_q != '1))           flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;

endmodule
